// File: rtl/transaction_checker.sv
// transaction_checker
//
// Self-checking monitor for the output side of the transaction layer. On every
// output-FIFO pop it compares the behavioural and synthesised words of that
// channel and checks that the popped word's destination field names the channel
// it left through. It keeps saturating per-channel word and error counters plus a
// saturating total, sticky fault flags, a frozen capture of the first fault, and
// a PASS/FAIL state.
//
// Ports:
//   clk            clock, all state on the rising edge
//   reset          asynchronous, active-low reset
//   clear          synchronous clear of counters, flags and state (wins over pop)
//   pop            per-channel pop strobe, bit i qualifies slice i
//   data_ref       behavioural words, slice i = [i*WORD_SIZE +: WORD_SIZE]
//   data_dut       synthesised words, same packing
//   req / idx      counter read request and channel select
//   valid          read data valid, one cycle after req
//   cuenta         popped-word count of the channel read
//   err_cnt        fault count of the channel read
//   total          popped words over all channels (always visible)
//   mismatch       sticky ref/dut compare failure
//   route_err      sticky destination/channel disagreement
//   first_err_ch   channel of the first fault
//   first_err_ref  ref word of the first fault
//   first_err_dut  dut word of the first fault
//   state          00 IDLE, 01 RUN, 10 FAIL

module transaction_checker #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned WORD_SIZE = 12,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned TOT_W     = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [N_CH-1:0]           pop,
    input  logic [N_CH*WORD_SIZE-1:0] data_ref,
    input  logic [N_CH*WORD_SIZE-1:0] data_dut,
    input  logic                      req,
    input  logic [IDX_W-1:0]          idx,
    output logic                      valid,
    output logic [CNT_W-1:0]          cuenta,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [TOT_W-1:0]          total,
    output logic                      mismatch,
    output logic                      route_err,
    output logic [IDX_W-1:0]          first_err_ch,
    output logic [WORD_SIZE-1:0]      first_err_ref,
    output logic [WORD_SIZE-1:0]      first_err_dut,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFail = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [TOT_W-1:0] TotMax = '1;

    // Registered state
    logic [CNT_W-1:0]     cnt_q [N_CH];
    logic [CNT_W-1:0]     err_q [N_CH];
    logic [TOT_W-1:0]     total_q;
    logic                 mismatch_q;
    logic                 route_q;
    logic [IDX_W-1:0]     first_ch_q;
    logic [WORD_SIZE-1:0] first_ref_q;
    logic [WORD_SIZE-1:0] first_dut_q;
    state_e               state_q;
    logic                 valid_q;
    logic [CNT_W-1:0]     cuenta_q;
    logic [CNT_W-1:0]     err_cnt_q;

    // Per-cycle fault detection
    logic [WORD_SIZE-1:0] ref_w [N_CH];
    logic [WORD_SIZE-1:0] dut_w [N_CH];
    logic [N_CH-1:0]      mis_vec;
    logic [N_CH-1:0]      rte_vec;
    logic [N_CH-1:0]      fault_vec;
    logic                 any_fault;
    logic                 any_pop;
    logic [IDX_W-1:0]     low_ch;
    logic [WORD_SIZE-1:0] low_ref;
    logic [WORD_SIZE-1:0] low_dut;
    logic [TOT_W-1:0]     total_d;
    int                   pop_num;
    int                   tot_sum;
    logic                 rd_in_range;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ref_w[i] = data_ref[i*WORD_SIZE +: WORD_SIZE];
            dut_w[i] = data_dut[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_comb begin
        mis_vec = '0;
        rte_vec = '0;
        pop_num = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (pop[i]) begin
                pop_num    = pop_num + 1;
                mis_vec[i] = (ref_w[i] != dut_w[i]);
                rte_vec[i] = (int'(ref_w[i][WORD_SIZE-3:WORD_SIZE-4]) != int'(i));
            end
        end
        fault_vec = mis_vec | rte_vec;
        any_fault = |fault_vec;
        any_pop   = |pop;
    end

    // Lowest faulting channel: scan downwards so the lowest index is assigned last.
    always_comb begin
        low_ch  = '0;
        low_ref = '0;
        low_dut = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (fault_vec[i]) begin
                low_ch  = IDX_W'(i);
                low_ref = ref_w[i];
                low_dut = dut_w[i];
            end
        end
    end

    // Total adds the whole popcount in one cycle, clamped at all-ones.
    always_comb begin
        tot_sum = int'(total_q) + pop_num;
        if (tot_sum > int'(TotMax)) begin
            total_d = TotMax;
        end else begin
            total_d = TOT_W'(tot_sum);
        end
    end

    assign rd_in_range = (int'(idx) < int'(N_CH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                err_q[i] <= '0;
            end
            total_q     <= '0;
            mismatch_q  <= 1'b0;
            route_q     <= 1'b0;
            first_ch_q  <= '0;
            first_ref_q <= '0;
            first_dut_q <= '0;
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            cuenta_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (clear) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    cnt_q[i] <= '0;
                    err_q[i] <= '0;
                end
                total_q     <= '0;
                mismatch_q  <= 1'b0;
                route_q     <= 1'b0;
                first_ch_q  <= '0;
                first_ref_q <= '0;
                first_dut_q <= '0;
                state_q     <= StIdle;
            end else begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (pop[i] && (cnt_q[i] != CntMax)) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                    // One error count per channel per cycle, even with both faults.
                    if (fault_vec[i] && (err_q[i] != CntMax)) begin
                        err_q[i] <= err_q[i] + 1'b1;
                    end
                end
                total_q <= total_d;
                if (|mis_vec) begin
                    mismatch_q <= 1'b1;
                end
                if (|rte_vec) begin
                    route_q <= 1'b1;
                end
                // The sticky flags double as "already captured": freeze after first.
                if (any_fault && !(mismatch_q || route_q)) begin
                    first_ch_q  <= low_ch;
                    first_ref_q <= low_ref;
                    first_dut_q <= low_dut;
                end
                case (state_q)
                    StIdle: begin
                        if (any_fault) begin
                            state_q <= StFail;
                        end else if (any_pop) begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (any_fault) begin
                            state_q <= StFail;
                        end
                    end
                    StFail:  state_q <= StFail;
                    default: state_q <= StIdle;
                endcase
            end

            // Read port returns the counters as they stood before this edge.
            valid_q <= req;
            if (req) begin
                if (rd_in_range) begin
                    cuenta_q  <= cnt_q[idx];
                    err_cnt_q <= err_q[idx];
                end else begin
                    cuenta_q  <= '0;
                    err_cnt_q <= '0;
                end
            end
        end
    end

    assign valid         = valid_q;
    assign cuenta        = cuenta_q;
    assign err_cnt       = err_cnt_q;
    assign total         = total_q;
    assign mismatch      = mismatch_q;
    assign route_err     = route_q;
    assign first_err_ch  = first_ch_q;
    assign first_err_ref = first_ref_q;
    assign first_err_dut = first_dut_q;
    assign state         = state_q;

endmodule

// File: tb/tb_transaction_checker.sv
module tb_transaction_checker;

    localparam int N_CH    = 4;
    localparam int WS      = 12;
    localparam int CNT_MAX = 31;
    localparam int TOT_MAX = 127;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  pop = '0;
    logic [47:0] data_ref = '0;
    logic [47:0] data_dut = '0;
    logic        req = 1'b0;
    logic [1:0]  idx = '0;
    logic        valid;
    logic [4:0]  cuenta;
    logic [4:0]  err_cnt;
    logic [6:0]  total;
    logic        mismatch;
    logic        route_err;
    logic [1:0]  first_err_ch;
    logic [11:0] first_err_ref;
    logic [11:0] first_err_dut;
    logic [1:0]  state;

    always #5 clk = ~clk;

    transaction_checker #(
        .N_CH     (4),
        .WORD_SIZE(12),
        .IDX_W    (2),
        .CNT_W    (5),
        .TOT_W    (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .pop          (pop),
        .data_ref     (data_ref),
        .data_dut     (data_dut),
        .req          (req),
        .idx          (idx),
        .valid        (valid),
        .cuenta       (cuenta),
        .err_cnt      (err_cnt),
        .total        (total),
        .mismatch     (mismatch),
        .route_err    (route_err),
        .first_err_ch (first_err_ch),
        .first_err_ref(first_err_ref),
        .first_err_dut(first_err_dut),
        .state        (state)
    );

    typedef struct {
        int vld;
        int tot;
        int mis;
        int rte;
        int st;
        int fch;
        int fref;
        int fdut;
    } status_t;

    typedef struct {
        int cnt;
        int err;
    } read_t;

    status_t st_q[$];
    read_t   rd_q[$];
    status_t mon_s;
    read_t   mon_r;

    // Reference model: plain integer bookkeeping of the checker's rules.
    int m_cnt[N_CH];
    int m_err[N_CH];
    int m_tot, m_mis, m_rte, m_st, m_fch, m_fref, m_fdut;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = 0;
            m_err[i] = 0;
        end
        m_tot = 0; m_mis = 0; m_rte = 0; m_st = 0; m_fch = 0; m_fref = 0; m_fdut = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic [47:0] r, input logic [47:0] d,
                              input logic rq, input logic [1:0] ix, input logic clr);
        int was_err;
        int got;
        int fault;
        was_err = m_mis | m_rte;
        got     = 0;
        fault   = 0;
        if (rq) rd_q.push_back('{cnt: m_cnt[ix], err: m_err[ix]});
        if (clr) begin
            model_reset();
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (p[i]) begin
                    logic [11:0] rw;
                    logic [11:0] dw;
                    int mis, rte;
                    rw = r[i*WS +: WS];
                    dw = d[i*WS +: WS];
                    mis = (rw != dw) ? 1 : 0;
                    rte = (int'(rw[9:8]) != i) ? 1 : 0;
                    m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
                    m_tot    = (m_tot < TOT_MAX) ? m_tot + 1 : TOT_MAX;
                    if (mis != 0) m_mis = 1;
                    if (rte != 0) m_rte = 1;
                    if (mis != 0 || rte != 0) begin
                        fault = 1;
                        m_err[i] = (m_err[i] < CNT_MAX) ? m_err[i] + 1 : CNT_MAX;
                        if (was_err == 0 && got == 0) begin
                            m_fch = i; m_fref = int'(rw); m_fdut = int'(dw); got = 1;
                        end
                    end
                end
            end
            if (fault != 0) m_st = 2;
            else if (m_st == 0 && p != 4'b0000) m_st = 1;
        end
        st_q.push_back('{vld: int'(rq), tot: m_tot, mis: m_mis, rte: m_rte, st: m_st,
                         fch: m_fch, fref: m_fref, fdut: m_fdut});
    endtask

    task automatic cycle(input logic [3:0] p, input logic [47:0] r, input logic [47:0] d,
                         input logic rq, input logic [1:0] ix, input logic clr);
        @(negedge clk);
        pop = p; data_ref = r; data_dut = d; req = rq; idx = ix; clear = clr;
        @(posedge clk);
        model_step(p, r, d, rq, ix, clr);
        #1;
    endtask

    function automatic logic [11:0] mk(input logic [1:0] dst, input logic [7:0] dat);
        return {2'b01, dst, dat};
    endfunction

    function automatic logic [47:0] good_vec();
        logic [47:0] v;
        for (int i = 0; i < N_CH; i++) v[i*WS +: WS] = mk(2'(i), 8'($urandom));
        return v;
    endfunction

    // Monitor: compares every registered output against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && st_q.size() > 0) begin
                mon_s = st_q.pop_front();
                chk("valid", 32'(valid), mon_s.vld);
                chk("total", 32'(total), mon_s.tot);
                chk("mismatch", 32'(mismatch), mon_s.mis);
                chk("route_err", 32'(route_err), mon_s.rte);
                chk("state", 32'(state), mon_s.st);
                chk("first_err_ch", 32'(first_err_ch), mon_s.fch);
                chk("first_err_ref", 32'(first_err_ref), mon_s.fref);
                chk("first_err_dut", 32'(first_err_dut), mon_s.fdut);
            end
            if (reset && valid) begin
                chk("read_pending", 32'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    mon_r = rd_q.pop_front();
                    chk("cuenta", 32'(cuenta), mon_r.cnt);
                    chk("err_cnt", 32'(err_cnt), mon_r.err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [47:0] r;
        logic [47:0] d;
        logic [11:0] saved_ref;

        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_total", 32'(total), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_first_ref", 32'(first_err_ref), 0);
        reset = 1'b1;

        // Four clean bursts on all channels.
        for (int n = 0; n < 4; n++) begin
            r = good_vec();
            cycle(4'b1111, r, r, 1'b0, 2'd0, 1'b0);
        end
        chk("tp_state_run", 32'(state), 1);
        chk("tp_total16", 32'(total), 16);
        chk("tp_nomis", 32'(mismatch), 0);
        for (int k = 0; k < N_CH; k++) begin
            cycle(4'b0000, r, r, 1'b1, 2'(k), 1'b0);
            chk("tp_cuenta4", 32'(cuenta), 4);
            chk("tp_err0", 32'(err_cnt), 0);
        end

        // Data mismatch on S2.
        r = good_vec(); d = r;
        r[2*WS +: WS] = 12'hA5C;
        d[2*WS +: WS] = 12'hA5D;
        cycle(4'b0100, r, d, 1'b0, 2'd0, 1'b0);
        chk("tp_mis1", 32'(mismatch), 1);
        chk("tp_fail", 32'(state), 2);
        chk("tp_fch2", 32'(first_err_ch), 2);
        chk("tp_fref", 32'(first_err_ref), 32'h0A5C);
        chk("tp_fdut", 32'(first_err_dut), 32'h0A5D);
        cycle(4'b0000, r, r, 1'b1, 2'd2, 1'b0);
        chk("tp_err2", 32'(err_cnt), 1);

        // Route error on S1 after a clear.
        cycle(4'b0000, r, r, 1'b0, 2'd0, 1'b1);
        r = good_vec();
        r[1*WS +: WS] = 12'h300;
        cycle(4'b0010, r, r, 1'b0, 2'd0, 1'b0);
        chk("tp_rte1", 32'(route_err), 1);
        chk("tp_rte_nomis", 32'(mismatch), 0);
        cycle(4'b0000, r, r, 1'b1, 2'd1, 1'b0);
        chk("tp_err1", 32'(err_cnt), 1);

        // Simultaneous faults on S3 and S0, then a later fault on S1.
        cycle(4'b0000, r, r, 1'b0, 2'd0, 1'b1);
        r = good_vec(); d = r;
        d[0] = ~d[0];
        d[3*WS] = ~d[3*WS];
        saved_ref = r[11:0];
        cycle(4'b1001, r, d, 1'b0, 2'd0, 1'b0);
        chk("tp_fch0", 32'(first_err_ch), 0);
        r = good_vec(); d = r;
        d[1*WS + 3] = ~d[1*WS + 3];
        cycle(4'b0010, r, d, 1'b0, 2'd0, 1'b0);
        chk("tp_frozen_ch", 32'(first_err_ch), 0);
        chk("tp_frozen_ref", 32'(first_err_ref), 32'(saved_ref));

        // Saturation on S0.
        cycle(4'b0000, r, r, 1'b0, 2'd0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            r = good_vec();
            cycle(4'b0001, r, r, 1'b0, 2'd0, 1'b0);
        end
        cycle(4'b0000, r, r, 1'b1, 2'd0, 1'b0);
        chk("tp_sat31", 32'(cuenta), 31);
        chk("tp_total40", 32'(total), 40);
        r = good_vec();
        cycle(4'b0001, r, r, 1'b0, 2'd0, 1'b1);
        chk("tp_clr_total", 32'(total), 0);
        chk("tp_clr_idle", 32'(state), 0);
        cycle(4'b0000, r, r, 1'b1, 2'd0, 1'b0);
        chk("tp_clr_cnt", 32'(cuenta), 0);

        // Reset in the middle of a burst with req held high.
        for (int n = 0; n < 3; n++) begin
            r = good_vec();
            cycle(4'b1111, r, r, 1'b1, 2'(n), 1'b0);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_valid", 32'(valid), 0);
        chk("mr_total", 32'(total), 0);
        chk("mr_state", 32'(state), 0);
        chk("mr_cuenta", 32'(cuenta), 0);
        model_reset();
        pop = '0; req = 1'b0; clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            r = good_vec();
            cycle(4'b1111, r, r, 1'b0, 2'd0, 1'b0);
        end
        chk("mr_resume_total", 32'(total), 8);
        cycle(4'b0000, r, r, 1'b1, 2'd3, 1'b0);
        chk("mr_resume_cnt", 32'(cuenta), 2);

        // Randomized traffic with occasional faults and clears.
        for (int n = 0; n < 500; n++) begin
            logic [3:0]  p;
            logic [11:0] w;
            p = 4'($urandom);
            r = '0;
            d = '0;
            for (int k = 0; k < N_CH; k++) begin
                w = mk(2'(k), 8'($urandom));
                if ($urandom_range(0, 9) == 0) w[9:8] = 2'($urandom);
                r[k*WS +: WS] = w;
                d[k*WS +: WS] = w;
                if ($urandom_range(0, 9) == 0) d[k*WS + $urandom_range(0, 11)] ^= 1'b1;
            end
            cycle(p, r, d, 1'($urandom), 2'($urandom), ($urandom_range(0, 29) == 0));
        end

        cycle(4'b0000, r, r, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("queues_drained", 32'(st_q.size() + rd_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
